// File: rtl/alu_iter_n_if.sv
// Operand/result bundle between the ID/EX latches and the iterative ALU.
interface alu_iter_n_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [4:0]       FS;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] T;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y_hi;
    logic [WIDTH-1:0] Y_lo;
    logic             C;
    logic             V;
    logic             N;
    logic             Z;
    logic             div0;

    modport master (
        output start, FS, S, T, shamt,
        input  busy, done, Y_hi, Y_lo, C, V, N, Z, div0
    );

    modport slave (
        input  start, FS, S, T, shamt,
        output busy, done, Y_hi, Y_lo, C, V, N, Z, div0
    );
endinterface

// File: rtl/alu_iter_n.sv
// Registered ALU: single-cycle logic/arith/shift ops plus iterative signed
// shift-add multiply and restoring divide behind a start/done handshake.
module alu_iter_n #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic       clk,
    input  logic       reset,
    alu_iter_n_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]     SH_ONE = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH);

    localparam logic [4:0] FS_PASS_S = 5'h00;
    localparam logic [4:0] FS_PASS_T = 5'h01;
    localparam logic [4:0] FS_ADD    = 5'h02;
    localparam logic [4:0] FS_ADDU   = 5'h03;
    localparam logic [4:0] FS_SUB    = 5'h04;
    localparam logic [4:0] FS_SUBU   = 5'h05;
    localparam logic [4:0] FS_SLT    = 5'h06;
    localparam logic [4:0] FS_SLTU   = 5'h07;
    localparam logic [4:0] FS_AND    = 5'h08;
    localparam logic [4:0] FS_OR     = 5'h09;
    localparam logic [4:0] FS_XOR    = 5'h0A;
    localparam logic [4:0] FS_NOR    = 5'h0B;
    localparam logic [4:0] FS_SRL    = 5'h0C;
    localparam logic [4:0] FS_SRA    = 5'h0D;
    localparam logic [4:0] FS_SLL    = 5'h0E;
    localparam logic [4:0] FS_MUL    = 5'h1E;
    localparam logic [4:0] FS_DIV    = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg_w(x) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + ONE_2W;
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;   // |S| for MUL, |T| for DIV, raw S for DIV by zero
    logic [2*WIDTH-1:0] prod_q, prod_d;     // MUL {acc, multiplier}; DIV {remainder, quotient}
    logic               sign_q, sign_d;     // product / quotient sign
    logic               rsign_q, rsign_d;   // remainder sign (dividend sign)
    logic               ovf_q, ovf_d;       // most-negative / -1 divide
    logic               dz_q, dz_d;         // divide by zero pending
    logic               is_div_q, is_div_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   y_hi_q, y_hi_d;
    logic [WIDTH-1:0]   y_lo_q, y_lo_d;
    logic               c_q, c_d;
    logic               v_q, v_d;
    logic               n_q, n_d;
    logic               z_q, z_d;
    logic               div0_q, div0_d;

    logic [WIDTH-1:0]   alu_y_s;
    logic               alu_c_s;
    logic               alu_v_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] mul_res_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Single-cycle result and C/V flags for every non-iterative function code.
    always_comb begin
        add_s   = {1'b0, bus.S} + {1'b0, bus.T};
        sub_s   = {1'b0, bus.S} + {1'b0, ~bus.T} + {{WIDTH{1'b0}}, 1'b1};
        alu_y_s = ZERO_W;
        alu_c_s = 1'b0;
        alu_v_s = 1'b0;
        case (bus.FS)
            FS_PASS_S: alu_y_s = bus.S;
            FS_PASS_T: alu_y_s = bus.T;
            FS_ADD: begin
                alu_y_s = add_s[WIDTH-1:0];
                alu_c_s = add_s[WIDTH];
                alu_v_s = (bus.S[WIDTH-1] == bus.T[WIDTH-1]) &&
                          (add_s[WIDTH-1] != bus.S[WIDTH-1]);
            end
            FS_ADDU: begin
                alu_y_s = add_s[WIDTH-1:0];
                alu_c_s = add_s[WIDTH];
            end
            FS_SUB: begin
                alu_y_s = sub_s[WIDTH-1:0];
                alu_c_s = sub_s[WIDTH];
                alu_v_s = (bus.S[WIDTH-1] != bus.T[WIDTH-1]) &&
                          (sub_s[WIDTH-1] != bus.S[WIDTH-1]);
            end
            FS_SUBU: begin
                alu_y_s = sub_s[WIDTH-1:0];
                alu_c_s = sub_s[WIDTH];
            end
            FS_SLT:  alu_y_s = {{(WIDTH-1){1'b0}}, ($signed(bus.S) < $signed(bus.T))};
            FS_SLTU: alu_y_s = {{(WIDTH-1){1'b0}}, (bus.S < bus.T)};
            FS_AND:  alu_y_s = bus.S & bus.T;
            FS_OR:   alu_y_s = bus.S | bus.T;
            FS_XOR:  alu_y_s = bus.S ^ bus.T;
            FS_NOR:  alu_y_s = ~(bus.S | bus.T);
            FS_SRL: begin
                alu_y_s = bus.T >> bus.shamt;
                alu_c_s = (bus.shamt != {SHW{1'b0}}) &&
                          (|(bus.T & (ONE_W << (bus.shamt - SH_ONE))));
            end
            FS_SRA: begin
                alu_y_s = $signed(bus.T) >>> bus.shamt;
                alu_c_s = (bus.shamt != {SHW{1'b0}}) &&
                          (|(bus.T & (ONE_W << (bus.shamt - SH_ONE))));
            end
            FS_SLL: begin
                alu_y_s = bus.T << bus.shamt;
                alu_c_s = (bus.shamt != {SHW{1'b0}}) &&
                          (|(bus.T & (MIN_W >> (bus.shamt - SH_ONE))));
            end
            default: alu_y_s = ZERO_W;
        endcase
    end

    // One multiply/divide iteration step and the sign fix-up of the final values.
    always_comb begin
        mul_sum_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                      (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        div_trial_s = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
        mul_res_s   = sign_q  ? neg_2w(prod_q) : prod_q;
        quo_s       = sign_q  ? neg_w(prod_q[WIDTH-1:0]) : prod_q[WIDTH-1:0];
        rem_s       = rsign_q ? neg_w(prod_q[2*WIDTH-1:WIDTH]) : prod_q[2*WIDTH-1:WIDTH];
    end

    // Control FSM: accept, iterate, fix up signs and publish results.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        sign_d   = sign_q;
        rsign_d  = rsign_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        is_div_d = is_div_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        y_hi_d   = y_hi_q;
        y_lo_d   = y_lo_q;
        c_d      = c_q;
        v_d      = v_q;
        n_d      = n_q;
        z_d      = z_q;
        div0_d   = div0_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    div0_d = 1'b0;
                    if (bus.FS == FS_MUL) begin
                        mcand_d  = abs_w(bus.S);
                        prod_d   = {ZERO_W, abs_w(bus.T)};
                        sign_d   = bus.S[WIDTH-1] ^ bus.T[WIDTH-1];
                        cnt_d    = CNT_INIT;
                        is_div_d = 1'b0;
                        dz_d     = 1'b0;
                        ovf_d    = 1'b0;
                        busy_d   = 1'b1;
                        state_d  = ST_MUL;
                    end else if (bus.FS == FS_DIV) begin
                        is_div_d = 1'b1;
                        busy_d   = 1'b1;
                        if (bus.T == ZERO_W) begin
                            // Nothing to iterate: keep S for the remainder output.
                            mcand_d = bus.S;
                            dz_d    = 1'b1;
                            ovf_d   = 1'b0;
                            state_d = ST_FIX;
                        end else begin
                            mcand_d = abs_w(bus.T);
                            prod_d  = {ZERO_W, abs_w(bus.S)};
                            sign_d  = bus.S[WIDTH-1] ^ bus.T[WIDTH-1];
                            rsign_d = bus.S[WIDTH-1];
                            ovf_d   = (bus.S == MIN_W) && (bus.T == ONES_W);
                            dz_d    = 1'b0;
                            cnt_d   = CNT_INIT;
                            state_d = ST_DIV;
                        end
                    end else begin
                        y_hi_d = ZERO_W;
                        y_lo_d = alu_y_s;
                        c_d    = alu_c_s;
                        v_d    = alu_v_s;
                        n_d    = alu_y_s[WIDTH-1];
                        z_d    = (alu_y_s == ZERO_W);
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                prod_d = {mul_sum_s, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DIV: begin
                if (!div_trial_s[WIDTH]) begin
                    prod_d = {div_trial_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                end else begin
                    prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_FIX: begin
                c_d = 1'b0;
                if (!is_div_q) begin
                    y_hi_d = mul_res_s[2*WIDTH-1:WIDTH];
                    y_lo_d = mul_res_s[WIDTH-1:0];
                    v_d    = 1'b0;
                    n_d    = mul_res_s[2*WIDTH-1];
                    z_d    = (mul_res_s == {(2*WIDTH){1'b0}});
                end else if (dz_q) begin
                    y_hi_d = mcand_q;
                    y_lo_d = ONES_W;
                    v_d    = 1'b0;
                    n_d    = 1'b1;
                    z_d    = 1'b0;
                    div0_d = 1'b1;
                end else begin
                    y_hi_d = rem_s;
                    y_lo_d = quo_s;
                    v_d    = ovf_q;
                    n_d    = quo_s[WIDTH-1];
                    z_d    = (quo_s == ZERO_W);
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            mcand_q  <= ZERO_W;
            prod_q   <= {(2*WIDTH){1'b0}};
            sign_q   <= 1'b0;
            rsign_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_hi_q   <= ZERO_W;
            y_lo_q   <= ZERO_W;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b1;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            sign_q   <= sign_d;
            rsign_q  <= rsign_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            is_div_q <= is_div_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            y_hi_q   <= y_hi_d;
            y_lo_q   <= y_lo_d;
            c_q      <= c_d;
            v_q      <= v_d;
            n_q      <= n_d;
            z_q      <= z_d;
            div0_q   <= div0_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Y_hi = y_hi_q;
    assign bus.Y_lo = y_lo_q;
    assign bus.C    = c_q;
    assign bus.V    = v_q;
    assign bus.N    = n_q;
    assign bus.Z    = z_q;
    assign bus.div0 = div0_q;
endmodule

// File: tb/tb_alu_iter_n.sv
// Self-checking bench for alu_iter_n (WIDTH=32): directed table, randomized
// ops against an arithmetic reference model, and multi-cycle corner sequences.
module tb_alu_iter_n;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_iter_n_if #(.WIDTH(32), .SHW(5)) bus ();

    alu_iter_n #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  fs;
        logic [31:0] s;
        logic [31:0] t;
        logic [4:0]  sh;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
        logic        d0;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t,
                                input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo,
                                input logic c, input logic v, input logic n, input logic z,
                                input logic d0);
        vec_t r;
        r.fs = fs; r.s = s; r.t = t; r.sh = sh; r.hi = hi; r.lo = lo;
        r.c = c; r.v = v; r.n = n; r.z = z; r.d0 = d0;
        return r;
    endfunction

    // Reference model: plain signed/unsigned arithmetic on wide integers.
    function automatic vec_t ref_model(input logic [4:0] fs, input logic [31:0] s,
                                       input logic [31:0] t, input logic [4:0] sh);
        vec_t   r;
        longint sa, ta, us, ut, p, q, m;
        int     k;
        sa = longint'($signed(s));
        ta = longint'($signed(t));
        us = longint'({32'd0, s});
        ut = longint'({32'd0, t});
        r = mk(fs, s, t, sh, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        case (fs)
            5'h00: r.lo = s;
            5'h01: r.lo = t;
            5'h02, 5'h03: begin
                r.lo = s + t;
                r.c  = (us + ut) >= 64'sd4294967296;
                if (fs == 5'h02) r.v = ((sa + ta) > 64'sd2147483647) || ((sa + ta) < -64'sd2147483648);
            end
            5'h04, 5'h05: begin
                r.lo = s - t;
                r.c  = (us >= ut);
                if (fs == 5'h04) r.v = ((sa - ta) > 64'sd2147483647) || ((sa - ta) < -64'sd2147483648);
            end
            5'h06: r.lo = (sa < ta) ? 32'd1 : 32'd0;
            5'h07: r.lo = (us < ut) ? 32'd1 : 32'd0;
            5'h08: r.lo = s & t;
            5'h09: r.lo = s | t;
            5'h0A: r.lo = s ^ t;
            5'h0B: r.lo = ~(s | t);
            5'h0C: begin
                r.lo = t >> sh;
                k = int'(sh) - 1;
                r.c = (sh != 5'd0) ? t[k] : 1'b0;
            end
            5'h0D: begin
                r.lo = 32'(ta >>> sh);
                k = int'(sh) - 1;
                r.c = (sh != 5'd0) ? t[k] : 1'b0;
            end
            5'h0E: begin
                r.lo = t << sh;
                k = 32 - int'(sh);
                r.c = (sh != 5'd0) ? t[k] : 1'b0;
            end
            5'h1E: begin
                p = sa * ta;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            5'h1F: begin
                if (t == 32'd0) begin
                    r.lo = 32'hFFFFFFFF;
                    r.hi = s;
                    r.d0 = 1'b1;
                end else if (s == 32'h80000000 && t == 32'hFFFFFFFF) begin
                    r.lo = 32'h80000000;
                    r.hi = 32'd0;
                    r.v  = 1'b1;
                end else begin
                    q = sa / ta;
                    m = sa % ta;
                    r.lo = q[31:0];
                    r.hi = m[31:0];
                end
            end
            default: r.lo = 32'd0;
        endcase
        if (fs == 5'h1E) begin
            r.n = r.hi[31];
            r.z = ({r.hi, r.lo} == 64'd0);
        end else begin
            r.n = r.lo[31];
            r.z = (r.lo == 32'd0);
        end
        return r;
    endfunction

    // Issue one op, wait (bounded) for done, compare everything.
    // Latency = rising edges after the accepting edge until done is registered.
    task automatic run_op(input vec_t v, input string name, input bit poke);
        int lat;
        int exp_lat;
        logic [31:0] held;
        if (v.fs == 5'h1E || (v.fs == 5'h1F && v.t != 32'd0)) exp_lat = 33;
        else if (v.fs == 5'h1F) exp_lat = 1;
        else exp_lat = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.FS = v.fs; bus.S = v.s; bus.T = v.t; bus.shamt = v.sh;
        @(negedge clk);
        bus.start = 1'b0;
        if (exp_lat > 0) chk({name, ".busy_after_accept"}, 64'(bus.busy), 64'd1);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (poke) begin
                bus.start = 1'b1; bus.FS = 5'h02; bus.S = $urandom; bus.T = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk({name, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({name, ".Y_hi"}, 64'(bus.Y_hi), 64'(v.hi));
        chk({name, ".Y_lo"}, 64'(bus.Y_lo), 64'(v.lo));
        chk({name, ".CVNZ"}, 64'({bus.C, bus.V, bus.N, bus.Z}), 64'({v.c, v.v, v.n, v.z}));
        chk({name, ".div0"}, 64'(bus.div0), 64'(v.d0));
        chk({name, ".busy_at_done"}, 64'(bus.busy), 64'd0);
        if (poke) begin
            held = bus.Y_lo;
            @(negedge clk);
            chk({name, ".no_relaunch_busy"}, 64'(bus.busy), 64'd0);
            chk({name, ".done_single_pulse"}, 64'(bus.done), 64'd0);
            chk({name, ".hold_Y_lo"}, 64'(bus.Y_lo), 64'(held));
        end
    endtask

    vec_t tbl[18];
    vec_t rv;
    int   pulses;

    initial begin
        checks = 0;
        errors = 0;
        bus.start = 1'b0; bus.FS = 5'd0; bus.S = 32'd0; bus.T = 32'd0; bus.shamt = 5'd0;

        //            fs     S             T             sh    Y_hi          Y_lo          C     V     N     Z     div0
        tbl[0]  = mk(5'h02, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[1]  = mk(5'h0D, 32'h00000000, 32'h80000000, 5'd4, 32'h00000000, 32'hF8000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[2]  = mk(5'h0E, 32'h00000000, 32'h00000001, 5'd0, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(5'h04, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[4]  = mk(5'h05, 32'h00000000, 32'h00000001, 5'd0, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk(5'h03, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[6]  = mk(5'h06, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(5'h07, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[8]  = mk(5'h0B, 32'h00000000, 32'h00000000, 5'd0, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(5'h0C, 32'h00000000, 32'h00000003, 5'd1, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(5'h0E, 32'h00000000, 32'h80000001, 5'd1, 32'h00000000, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(5'h1E, 32'hFFFFFFFE, 32'h00000003, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[12] = mk(5'h1F, 32'hFFFFFFF9, 32'h00000002, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[13] = mk(5'h1F, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tbl[14] = mk(5'h1F, 32'h00000005, 32'h00000000, 5'd0, 32'h00000005, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tbl[15] = mk(5'h10, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[16] = mk(5'h1E, 32'h00000000, 32'h00000005, 5'd0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[17] = mk(5'h01, 32'h11111111, 32'hCAFEF00D, 5'd0, 32'h00000000, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.busy", 64'(bus.busy), 64'd0);
        chk("reset.done", 64'(bus.done), 64'd0);
        chk("reset.Y", 64'({bus.Y_hi, bus.Y_lo}), 64'd0);
        chk("reset.CVNZ_div0", 64'({bus.C, bus.V, bus.N, bus.Z, bus.div0}), 64'b00010);
        reset = 1'b0;

        // Directed table; iterative entries also get start pulses while busy.
        for (int i = 0; i < 18; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i), (tbl[i].fs == 5'h1E || tbl[i].fs == 5'h1F));
        end

        // Randomized ops against the reference model.
        for (int i = 0; i < 120; i++) begin
            int sel;
            logic [4:0]  fs;
            logic [31:0] s;
            logic [31:0] t;
            logic [4:0]  sh;
            sel = $urandom_range(0, 17);
            if (sel <= 14) fs = 5'(sel);
            else if (sel == 15) fs = 5'h1E;
            else if (sel == 16) fs = 5'h1F;
            else fs = 5'h14;
            s  = $urandom;
            t  = $urandom;
            sh = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) t = 32'd0;
            if ($urandom_range(0, 7) == 0) s = 32'h80000000;
            if ($urandom_range(0, 7) == 0) t = 32'hFFFFFFFF;
            rv = ref_model(fs, s, t, sh);
            run_op(rv, $sformatf("rnd%0d_fs%0h", i, fs), 1'b0);
        end

        // Reset in the middle of a MUL: aborted, no done ever appears.
        run_op(tbl[0], "pre_abort_add", 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.FS = 5'h1E; bus.S = 32'd3; bus.T = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.busy", 64'(bus.busy), 64'd0);
        chk("abort.Y_lo", 64'(bus.Y_lo), 64'd0);
        chk("abort.Z", 64'(bus.Z), 64'd1);
        chk("abort.done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        chk("abort.no_done", 64'(pulses), 64'd0);

        // Still functional after the abort.
        run_op(tbl[12], "post_abort_div", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
